// File: rtl/stepper_pkg.sv
// Shared types and constants for the step/dir pulse generator: FSM states,
// control-register bit positions, default timing parameters and the period floor helper.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_SPACE = 2'd3
  } state_t;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_ZERO_BIT = 1;

  localparam int DEF_PULSE_W   = 8;
  localparam int DEF_DIR_SETUP = 4;

  // Unsigned max of the requested period and the minimum legal period.
  function automatic logic [32:0] eff_period(input logic [32:0] period,
                                             input logic [32:0] floor_val);
    return (period > floor_val) ? period : floor_val;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Config-in / motion-out bundle between the SPI register slave and step_pulse_gen.
// ramp_cfg only exists when STEP_RAMP_EN is defined.
interface step_pulse_gen_if;
  import stepper_pkg::*;

  // cfg_load is a one-cycle valid strobe with no ready: the generator always
  // accepts it, and all config words must be stable in the same cycle.
  logic        cfg_load;
  logic [31:0] target_pos;
  logic [31:0] step_period;
  logic [31:0] ctrl;
`ifdef STEP_RAMP_EN
  logic [31:0] ramp_cfg;
`endif

  logic        o_step;
  logic        o_dir;
  logic        o_enable;
  logic        o_busy;
  logic [31:0] o_position;
  state_t      fsm_state;

  modport master (
    output cfg_load, target_pos, step_period, ctrl,
`ifdef STEP_RAMP_EN
    output ramp_cfg,
`endif
    input  o_step, o_dir, o_enable, o_busy, o_position, fsm_state
  );

  modport slave (
    input  cfg_load, target_pos, step_period, ctrl,
`ifdef STEP_RAMP_EN
    input  ramp_cfg,
`endif
    output o_step, o_dir, o_enable, o_busy, o_position, fsm_state
  );

endinterface

// File: rtl/step_period_timer.sv
// Loadable down-counter shared by all timed FSM states; tc is high once the
// count has reached zero, so a load of N-1 gives a state lasting N cycles.
module step_period_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [32:0] load_val,
  output logic        tc
);

  logic [32:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 33'd1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR/ENABLE generator with absolute position tracking.
// Optional start-fast ramp (ramp_cfg) is compiled in with `define STEP_RAMP_EN.
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int PULSE_W   = DEF_PULSE_W,
  parameter int DIR_SETUP = DEF_DIR_SETUP
) (
  input  logic           clk,
  input  logic           i_Rst_L,
  step_pulse_gen_if.slave bus
);

  localparam logic [32:0] PERIOD_FLOOR = 33'(2 * PULSE_W);
  localparam logic [32:0] PULSE_LOAD   = 33'(PULSE_W - 1);
  localparam logic [32:0] SETUP_LOAD   = 33'(DIR_SETUP - 1);

  state_t      state_q, state_d;
  logic [31:0] tgt_q, per_q, pos_q;
  logic        en_q, dir_q, dir_d, step_q, busy_q;
  logic        tmr_load, tmr_tc;
  logic [32:0] tmr_val;
  logic [32:0] cur_period;
  logic [32:0] space_load;
  logic        want_up, at_target;
  logic        pulse_entry, setup_entry, space_entry;
  logic        ctrl_unused;

  assign ctrl_unused = ^bus.ctrl[31:2];

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tgt_q <= '0;
      per_q <= '0;
      en_q  <= 1'b0;
    end else if (bus.cfg_load) begin
      tgt_q <= bus.target_pos;
      per_q <= bus.step_period;
      en_q  <= bus.ctrl[CTRL_EN_BIT];
    end
  end

  assign want_up   = $signed(tgt_q) > $signed(pos_q);
  assign at_target = (tgt_q == pos_q);

  assign pulse_entry = (state_d == ST_PULSE) && (state_q != ST_PULSE);
  assign setup_entry = (state_d == ST_SETUP) && (state_q != ST_SETUP);
  assign space_entry = (state_d == ST_SPACE) && (state_q != ST_SPACE);

`ifdef STEP_RAMP_EN
  logic [31:0] ramp_q;
  logic [32:0] cur_q;
  logic [32:0] ramp_dec;
  logic [32:0] per_ext;

  assign ramp_dec = {17'b0, ramp_q[15:0]};
  assign per_ext  = {1'b0, per_q};

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ramp_q <= '0;
    end else if (bus.cfg_load) begin
      ramp_q <= bus.ramp_cfg;
    end
  end

  // Each direction start begins slow and speeds up after every pulse,
  // never going below the programmed period.
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cur_q <= '0;
    end else if (setup_entry) begin
      cur_q <= per_ext + {17'b0, ramp_q[31:16]};
    end else if (space_entry) begin
      cur_q <= (cur_q < per_ext + ramp_dec) ? per_ext : (cur_q - ramp_dec);
    end
  end

  assign cur_period = cur_q;
`else
  assign cur_period = {1'b0, per_q};
`endif

  assign space_load = eff_period(cur_period, PERIOD_FLOOR) - 33'(PULSE_W) - 33'd1;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && !at_target) begin
          state_d  = ST_SETUP;
          dir_d    = want_up;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (tmr_tc) begin
          state_d  = ST_SPACE;
          tmr_load = 1'b1;
          tmr_val  = space_load;
        end
      end
      ST_SPACE: begin
        if (tmr_tc) begin
          if (!en_q || at_target) begin
            state_d = ST_IDLE;
          end else if (want_up == dir_q) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
          end else begin
            state_d  = ST_SETUP;
            dir_d    = want_up;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= (state_d == ST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
      // Position moves on the STEP rising edge; zeroing is only honoured at rest.
      if (pulse_entry) begin
        pos_q <= dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
      end else if (bus.cfg_load && bus.ctrl[CTRL_ZERO_BIT] && (state_q == ST_IDLE)) begin
        pos_q <= '0;
      end
    end
  end

  step_period_timer u_timer (
    .clk      (clk),
    .rst_n    (i_Rst_L),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign bus.o_step     = step_q;
  assign bus.o_dir      = dir_q;
  assign bus.o_enable   = en_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_position = pos_q;
  assign bus.fsm_state  = state_q;

endmodule
